encoder_period: RTL and testbench

- Quadrature encoder front end for the pendulum/cart motor loop.
- Samples the motor encoder A/B channels and maintains a signed 4x position count.
- Measures the signed time between successive A rising edges. This is the signed period consumed by the force-to-duty block.
- Sign encodes direction. 32'h7fffffff is the sentinel for "stopped / unknown".

---
 rtl/encoder_period.sv | 104 ++++++++++
 tb/tb_encoder_period.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/encoder_period.sv
// encoder_period: quadrature encoder front end producing a signed 4x position and a signed A-cycle period
module encoder_period #(
    parameter logic [31:0] TIMEOUT    = 32'd5000000,
    parameter logic [31:0] MIN_PERIOD = 32'd50,
    parameter logic [31:0] PERIOD_MAX = 32'h7fffffff
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic               pos_clear,
    output logic signed [31:0] period,
    output logic               period_valid,
    output logic signed [31:0] position,
    output logic               moving,
    output logic               quad_error
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t             state, state_nx;
    logic        [31:0] cnt, cnt_nx;
    logic               last_dir, last_dir_nx;
    logic signed [31:0] period_nx;
    logic               period_valid_nx;
    logic               a_m, a_s, a_p, b_m, b_s, b_p;
    logic               a_rise, dir, step_fwd, step_rev, step_err;
    logic        [3:0]  tr;

    assign tr       = {a_p, b_p, a_s, b_s};
    assign step_fwd = (tr == 4'b0010) || (tr == 4'b1011) || (tr == 4'b1101) || (tr == 4'b0100);
    assign step_rev = (tr == 4'b0001) || (tr == 4'b0111) || (tr == 4'b1110) || (tr == 4'b1000);
    assign step_err = (a_p ^ a_s) & (b_p ^ b_s);
    assign a_rise   = !a_p && a_s;
    assign dir      = b_s;
    assign moving   = (state == RUN);

    // two-flop synchronizer per channel plus a previous-value stage for transition decode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {a_m, a_s, a_p, b_m, b_s, b_p} <= '0;
        end else begin
            a_m <= enc_a;
            a_s <= a_m;
            a_p <= a_s;
            b_m <= enc_b;
            b_s <= b_m;
            b_p <= b_s;
        end
    end

    // 4x position count; clear beats a simultaneous step, double-bit changes flag an error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            position   <= '0;
            quad_error <= 1'b0;
        end else begin
            quad_error <= step_err;
            position   <= pos_clear ? 32'sd0 : step_fwd ? position + 32'sd1 : step_rev ? position - 32'sd1 : position;
        end
    end

    // period state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            last_dir     <= 1'b0;
            period       <= PERIOD_MAX;
            period_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            last_dir     <= last_dir_nx;
            period       <= period_nx;
            period_valid <= period_valid_nx;
        end
    end

    // edge acceptance, glitch rejection, reversal and timeout handling
    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        last_dir_nx     = last_dir;
        period_nx       = period;
        period_valid_nx = 1'b0;
        if (state == IDLE) begin
            if (a_rise) begin
                state_nx    = RUN;
                cnt_nx      = 32'd1;
                last_dir_nx = dir;
            end
        end else if (a_rise && cnt >= MIN_PERIOD) begin
            cnt_nx          = 32'd1;
            last_dir_nx     = dir;
            period_valid_nx = (dir == last_dir);
            period_nx       = (dir != last_dir) ? PERIOD_MAX : dir ? -cnt : cnt;
        end else if (!a_rise && cnt >= TIMEOUT) begin
            state_nx  = IDLE;
            cnt_nx    = '0;
            period_nx = PERIOD_MAX;
        end else begin
            cnt_nx = (cnt >= TIMEOUT) ? TIMEOUT : cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_encoder_period.sv
// tb_encoder_period: directed checks of position decode, period measurement, glitch, timeout and reset
module tb_encoder_period;
    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               enc_a = 1'b0;
    logic               enc_b = 1'b0;
    logic               pos_clear = 1'b0;
    logic signed [31:0] period;
    logic               period_valid;
    logic signed [31:0] position;
    logic               moving;
    logic               quad_error;
    int                 n_checks = 0;
    int                 n_fail = 0;
    int                 n_valid = 0;
    int                 n_qerr = 0;
    logic        [31:0] last_period = 32'h0;
    int                 w;

    localparam logic [31:0] PMAX = 32'h7fffffff;

    encoder_period #(.TIMEOUT(32'd5000), .MIN_PERIOD(32'd50), .PERIOD_MAX(PMAX)) dut (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .pos_clear(pos_clear),
        .period(period), .period_valid(period_valid), .position(position),
        .moving(moving), .quad_error(quad_error)
    );

    always #5 clk = ~clk;

    // record strobes and error pulses away from the active edge
    always @(negedge clk) begin
        if (period_valid) begin
            n_valid++;
            last_period = period;
        end
        if (quad_error) n_qerr++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        @(negedge clk);
        enc_a = a;
        enc_b = b;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic quad_cycle(input logic rev);
        if (!rev) begin
            hold(1, 0, 250); hold(1, 1, 250); hold(0, 1, 250); hold(0, 0, 250);
        end else begin
            hold(0, 1, 250); hold(1, 1, 250); hold(1, 0, 250); hold(0, 0, 250);
        end
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_period", period, PMAX);
        check("rst_position", position, 32'd0);
        check("rst_moving", 32'(moving), 32'd0);
        check("rst_valid", 32'(period_valid), 32'd0);
        check("rst_qerr", 32'(quad_error), 32'd0);
        reset_n = 1'b1;
        quad_cycle(0);
        check("fwd_first_nostrobe", 32'(n_valid), 32'd0);
        check("fwd_first_period", period, PMAX);
        check("fwd_first_moving", 32'(moving), 32'd1);
        repeat (9) quad_cycle(0);
        check("fwd_strobes", 32'(n_valid), 32'd9);
        check("fwd_period", last_period, 32'd1000);
        check("fwd_position", position, 32'd40);
        n_valid = 0;
        quad_cycle(1);
        check("rev_first_period", period, PMAX);
        check("rev_first_nostrobe", 32'(n_valid), 32'd0);
        check("rev_first_position", position, 32'd36);
        repeat (9) quad_cycle(1);
        check("rev_strobes", 32'(n_valid), 32'd9);
        check("rev_period", last_period, 32'hfffffc18);
        check("rev_position", position, 32'd0);
        repeat (4000) @(negedge clk);
        check("pre_timeout_moving", 32'(moving), 32'd1);
        check("pre_timeout_period", period, 32'hfffffc18);
        w = 0;
        while (moving && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("timeout_latency", 32'(w), 32'd254);
        check("timeout_period", period, PMAX);
        n_valid = 0;
        quad_cycle(0);
        check("restart_nostrobe", 32'(n_valid), 32'd0);
        check("restart_moving", 32'(moving), 32'd1);
        check("restart_period", period, PMAX);
        n_valid = 0;
        hold(1, 0, 5); hold(0, 0, 5); hold(1, 0, 240);
        hold(1, 1, 250); hold(0, 1, 250); hold(0, 0, 250);
        check("glitch_strobes", 32'(n_valid), 32'd1);
        check("glitch_period", last_period, 32'd1000);
        quad_cycle(0);
        check("after_glitch_strobes", 32'(n_valid), 32'd2);
        check("after_glitch_period", last_period, 32'd1000);
        check("glitch_position", position, 32'd12);
        n_qerr = 0;
        hold(1, 1, 20);
        check("qerr_first", 32'(n_qerr), 32'd1);
        check("qerr_position", position, 32'd12);
        hold(0, 0, 20);
        check("qerr_second", 32'(n_qerr), 32'd2);
        check("qerr_position2", position, 32'd12);
        @(negedge clk);
        enc_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pos_clear = 1'b1;
        @(negedge clk);
        pos_clear = 1'b0;
        check("clear_coincident", position, 32'd0);
        repeat (6) @(negedge clk);
        check("clear_hold", position, 32'd0);
        hold(1, 1, 250); hold(0, 1, 250); hold(0, 0, 300);
        check("clear_position", position, 32'd3);
        quad_cycle(0);
        quad_cycle(0);
        hold(1, 0, 100);
        #3 reset_n = 1'b0;
        #1;
        check("arst_period", period, PMAX);
        check("arst_position", position, 32'd0);
        check("arst_moving", 32'(moving), 32'd0);
        check("arst_valid", 32'(period_valid), 32'd0);
        enc_a = 1'b0;
        enc_b = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        n_valid = 0;
        quad_cycle(0);
        quad_cycle(0);
        check("post_rst_strobes", 32'(n_valid), 32'd1);
        check("post_rst_period", last_period, 32'd1000);
        check("post_rst_position", position, 32'd8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
